// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: op codes,
// FSM encoding, divider iteration constants and the divide-by-zero result.
package muldiv_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   localparam int DIV_ITER  = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITER);

   localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

   // Two's-complement magnitude; -2^31 maps to 0x80000000 read as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter_core.sv
// Restoring radix-2 divider datapath: partial remainder, shifting quotient and
// divisor registers. Operates on unsigned magnitudes; sequencing lives outside.
module div_iter_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      shifted = {rem_q, quo_q[WIDTH-1]};
      // Bit WIDTH of the trial difference is the borrow: set means restore.
      trial   = shifted - {1'b0, dvs_q};
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
      end else if (step) begin
         if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer with stall request and HI/LO
// write outputs. Optional macro MULDIV_EARLY_OUT_EN skips the divide when |a| < |b|.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall_ex,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             stallreq_md,
   output logic             md_busy,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata
);

   localparam logic [DIV_CNT_W-1:0] MUL_LAST = DIV_CNT_W'(MUL_LAT - 1);
   localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_ITER - 1);

   md_state_e              state_q, state_d;
   logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
   logic                   mul_sgn_q, mul_sgn_d;
   logic                   q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic                   src_div_q, src_div_d;

   logic                   accept, div_sgn, div_load, div_step;
   logic [WIDTH-1:0]       mag_a, mag_b, quo_raw, rem_raw, quo_fix, rem_fix;
   logic [2*WIDTH-1:0]     ext_a, ext_b, prod;

   div_iter_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo_raw),
      .remainder (rem_raw)
   );

   assign ext_a   = {{WIDTH{mul_sgn_q & a_q[WIDTH-1]}}, a_q};
   assign ext_b   = {{WIDTH{mul_sgn_q & b_q[WIDTH-1]}}, b_q};
   assign prod    = ext_a * ext_b;
   assign quo_fix = q_neg_q ? (~quo_raw + 1'b1) : quo_raw;
   assign rem_fix = r_neg_q ? (~rem_raw + 1'b1) : rem_raw;
   assign md_busy = (state_q != ST_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      mul_sgn_d   = mul_sgn_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      src_div_d   = src_div_q;
      div_load    = 1'b0;
      div_step    = 1'b0;
      stallreq_md = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
      hi_wdata    = '0;
      lo_wdata    = '0;
      div_sgn     = (op_code == MD_DIV);
      mag_a       = mag32(op_a, div_sgn);
      mag_b       = mag32(op_b, div_sgn);
      // Reset is folded in so MTHI/MTLO cannot leak a write while rst is high.
      accept      = op_valid & ~flush & ~rst;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_code)
                  MD_MTHI: begin
                     hi_we    = 1'b1;
                     hi_wdata = op_a;
                  end
                  MD_MTLO: begin
                     lo_we    = 1'b1;
                     lo_wdata = op_a;
                  end
                  MD_MULT, MD_MULTU: begin
                     stallreq_md = 1'b1;
                     a_d         = op_a;
                     b_d         = op_b;
                     mul_sgn_d   = (op_code == MD_MULT);
                     cnt_d       = '0;
                     state_d     = ST_MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     stallreq_md = 1'b1;
                     a_d         = op_a;
                     b_d         = op_b;
                     q_neg_d     = div_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                     r_neg_d     = div_sgn & op_a[WIDTH-1];
                     if (op_b == '0) begin
                        hi_d      = op_a;
                        lo_d      = DIV_ZERO_LO;
                        src_div_d = 1'b0;
                        state_d   = ST_DONE;
                     end
`ifdef MULDIV_EARLY_OUT_EN
                     else if (mag_a < mag_b) begin
                        // Quotient 0; remainder |a| re-signed as a is just a.
                        hi_d      = op_a;
                        lo_d      = '0;
                        src_div_d = 1'b0;
                        state_d   = ST_DONE;
                     end
`endif
                     else begin
                        div_load  = 1'b1;
                        cnt_d     = '0;
                        src_div_d = 1'b1;
                        state_d   = ST_DIV;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            stallreq_md = 1'b1;
            if (cnt_q == MUL_LAST) begin
               hi_d      = prod[2*WIDTH-1:WIDTH];
               lo_d      = prod[WIDTH-1:0];
               src_div_d = 1'b0;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + DIV_CNT_W'(1);
            end
         end
         ST_DIV: begin
            stallreq_md = 1'b1;
            div_step    = 1'b1;
            if (cnt_q == DIV_LAST) state_d = ST_DONE;
            else                   cnt_d   = cnt_q + DIV_CNT_W'(1);
         end
         ST_DONE: begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = src_div_q ? rem_fix : hi_q;
            lo_wdata = src_div_q ? quo_fix : lo_q;
            if (!stall_ex) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d     = ST_IDLE;
         stallreq_md = 1'b0;
         hi_we       = 1'b0;
         lo_we       = 1'b0;
         div_load    = 1'b0;
         div_step    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         mul_sgn_q <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         src_div_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mul_sgn_q <= mul_sgn_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         src_div_q <= src_div_d;
      end
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX decode.
- Sequences a fixed-latency multiplier and a 32-iteration radix-2 divider.
- Raises a stall request while busy, then presents HI/LO write data and enables that travel with the EX-to-MEM bus.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 supported.
- MUL_LAT, 1, cycles spent in MUL state, range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  abort current op, no HI/LO write.
- stall_ex  in  1  EX stage held by a downstream stall (stall[3]).
- op_valid  in  1  EX holds a mul/div/mthi/mtlo op.
- op_code  in  3  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- op_a  in  32  rs value (dividend/multiplicand/mthi-mtlo source).
- op_b  in  32  rt value.
- stallreq_md  out  1  stall request to the pipeline controller.
- md_busy  out  1  FSM not IDLE.
- hi_we  out  1  HI write enable.
- lo_we  out  1  LO write enable.
- hi_wdata  out  32  HI write data.
- lo_wdata  out  32  LO write data.

Behaviour:
- Reset (async): state IDLE; all outputs 0; operand/result registers 0.
- A reset mid-operation aborts immediately; no write is issued.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Accept when op_valid & !flush; operands are latched on accept (cycle 0).
  - MTHI/MTLO: combinational hi_we/lo_we = 1 with wdata = op_a, in the same cycle; no stall; stay IDLE.
  - MULT/MULTU: go to MUL; stallreq_md = 1 combinationally in cycle 0.
  - DIV/DIVU with op_b != 0: go to DIV; stallreq_md = 1.
  - DIV/DIVU with op_b == 0: go directly to DONE with lo = 0xFFFFFFFF, hi = op_a.
- MUL: count MUL_LAT cycles, then DONE. Total stall = MUL_LAT + 1 cycles.
  - MULT: signed 64-bit product. MULTU: unsigned. hi = [63:32], lo = [31:0].
- DIV:
  - Signed ops first take magnitudes.
  - 32 restoring shift-subtract iterations, one per cycle, with a 5-bit counter; 0 -> 31 then DONE.
  - Fixup: quotient negated if sign(a) ^ sign(b); remainder takes sign(a).
  - lo = quotient, hi = remainder.
  - Latency: accept cycle 0, iterations cycles 1..32, DONE at cycle 33.
- DONE:
  - stallreq_md = 0; hi_we = lo_we = 1; wdata stable.
  - Exit to IDLE when stall_ex = 0; remain in DONE while stall_ex = 1.
  - Any op_valid seen in DONE is the same instruction and is not re-accepted.
- stallreq_md = 1 in cycle 0 (for mul/div) and in MUL/DIV, except when flush is asserted.
- flush:
  - In any state: next state IDLE; write enables and stallreq_md forced 0 in that cycle.
  - flush with op_valid in IDLE: flush wins, nothing accepted or written.
- Arithmetic: -2^31 / -1 gives quotient 0x80000000, remainder 0. No overflow trap.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: at accept, if |a| < |b| (unsigned magnitudes, b != 0), skip DIV and go to DONE.
  - Results: quotient 0, remainder a (sign per fixup rule); total stall 1 cycle.
- Undefined: every nonzero-divisor divide takes the full 33 cycles.

Decomposition:
- Shared muldiv_pkg:
  - op_code localparams (MD_*).
  - FSM state encoding.
  - DIV_ITER = 32 and counter width.
  - Div-by-zero result constant 0xFFFFFFFF.
- One sub-module, div_iter_core: holds the partial remainder/quotient register.
  - Inputs: load, step, unsigned magnitudes.
  - Outputs: raw quotient/remainder.
  - FSM, counter, sign fixup and multiplier pipeline stay in muldiv_ctrl.

Test Plan:
- DIVU a=100, b=7 -> stallreq_md high cycles 0..32; DONE at cycle 33 with lo=14, hi=2, hi_we=lo_we=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE after MUL_LAT+1 cycles; MULTU same operands -> hi=1, lo=0xFFFFFFFE.
- DIV a=5, b=0 -> DONE next cycle, lo=0xFFFFFFFF, hi=5; MTLO a=0x1234 -> lo_we=1, lo_wdata=0x1234 same cycle, stallreq_md=0.
- flush at cycle 10 of DIVU -> no hi_we/lo_we, stallreq_md=0, IDLE next cycle; DIVU 9/3 accepted after -> lo=3, hi=0.
- stall_ex=1 for 3 cycles on DONE entry -> outputs held stable 3 cycles, IDLE after stall_ex falls, single accept only.
- Async rst pulse mid-DIV -> all outputs 0 without a clock edge.
- With MULDIV_EARLY_OUT_EN: DIVU 3/7 -> DONE at cycle 1, lo=0, hi=3.
